hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage MIPS core. It consumes the decoded control signals of the instruction in ID and the branch outcome from EX. It keeps a registered shadow of the EX, MEM and WB stages (dest register, RegWrite, MemRead, sources), and produces stall, flush and forwarding selects. It sits beside the control decoder at the downstream end of its outputs.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_ctrl_fwd_match.sv | 13 +
 rtl/hazard_ctrl.sv | 76 +++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings and the shadow-stage entry for the hazard controller.
package hazard_pkg;
    localparam int REG_ADDR_W = 5;
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR = 2'b01;
    localparam logic [1:0] PC_J = 2'b10;
    localparam logic [1:0] PC_JR = 2'b11;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
    typedef struct packed {
        logic valid;
        logic regwrite;
        logic memread;
        logic [REG_ADDR_W-1:0] waddr;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic usesRs;
        logic usesRt;
    } stage_entry_t;
endpackage

// File: rtl/hazard_ctrl_fwd_match.sv
// fwd_match: true when a used source register is written by a real writer (never $0).
module fwd_match
    import hazard_pkg::*;
(
    input  logic                  valid,
    input  logic                  regWrite,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  useSrc,
    output logic                  match
);
    assign match = valid & regWrite & (waddr != REG_ZERO) & useSrc & (src == waddr);
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control from a registered EX/MEM/WB shadow.
// Define FORWARD_EN for forwarding with load-use stalls only; otherwise stall on any EX/MEM dependency.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ID_Valid,
    input  logic [REG_ADDR_W-1:0]  ID_Rs,
    input  logic [REG_ADDR_W-1:0]  ID_Rt,
    input  logic                   ID_UsesRs,
    input  logic                   ID_UsesRt,
    input  logic                   ID_RegWrite,
    input  logic [REG_ADDR_W-1:0]  ID_WriteAddr,
    input  logic                   ID_MemRead,
    input  logic [1:0]             ID_PCSrc,
    input  logic                   EX_BranchTaken,
    output logic                   Stall,
    output logic                   Flush_IF_ID,
    output logic                   Flush_ID_EX,
    output logic [1:0]             ForwardA,
    output logic [1:0]             ForwardB,
    output logic [STALL_CNT_W-1:0] StallCount
);
`ifdef FORWARD_EN
    localparam logic FWD_ON = 1'b1;
`else
    localparam logic FWD_ON = 1'b0;
`endif
    stage_entry_t ex, mem, wb;
    logic idRsEx, idRtEx, idRsMem, idRtMem;
    logic exRsMem, exRtMem, exRsWb, exRtWb;
    logic loadUse, hazard, branch, jump;
    logic unusedBits;
    fwd_match mIdRsEx (.valid(ex.valid), .regWrite(ex.regwrite), .waddr(ex.waddr), .src(ID_Rs), .useSrc(ID_UsesRs), .match(idRsEx));
    fwd_match mIdRtEx (.valid(ex.valid), .regWrite(ex.regwrite), .waddr(ex.waddr), .src(ID_Rt), .useSrc(ID_UsesRt), .match(idRtEx));
    fwd_match mIdRsMem (.valid(mem.valid), .regWrite(mem.regwrite), .waddr(mem.waddr), .src(ID_Rs), .useSrc(ID_UsesRs), .match(idRsMem));
    fwd_match mIdRtMem (.valid(mem.valid), .regWrite(mem.regwrite), .waddr(mem.waddr), .src(ID_Rt), .useSrc(ID_UsesRt), .match(idRtMem));
    fwd_match mExRsMem (.valid(mem.valid), .regWrite(mem.regwrite), .waddr(mem.waddr), .src(ex.rs), .useSrc(ex.usesRs), .match(exRsMem));
    fwd_match mExRtMem (.valid(mem.valid), .regWrite(mem.regwrite), .waddr(mem.waddr), .src(ex.rt), .useSrc(ex.usesRt), .match(exRtMem));
    fwd_match mExRsWb (.valid(wb.valid), .regWrite(wb.regwrite), .waddr(wb.waddr), .src(ex.rs), .useSrc(ex.usesRs), .match(exRsWb));
    fwd_match mExRtWb (.valid(wb.valid), .regWrite(wb.regwrite), .waddr(wb.waddr), .src(ex.rt), .useSrc(ex.usesRt), .match(exRtWb));
    assign unusedBits = ^{wb.memread, wb.rs, wb.rt, wb.usesRs, wb.usesRt,
                          mem.rs, mem.rt, mem.usesRs, mem.usesRt};
    always_comb begin
        loadUse = ID_Valid & ex.memread & (idRsEx | idRtEx);
        hazard = FWD_ON ? loadUse : ID_Valid & (idRsEx | idRtEx | idRsMem | idRtMem);
        branch = ~reset & EX_BranchTaken;
        jump = ~reset & ID_Valid & (ID_PCSrc == PC_J || ID_PCSrc == PC_JR);
        Stall = ~reset & ~branch & hazard;
        Flush_IF_ID = branch | (jump & ~Stall);
        Flush_ID_EX = branch | Stall;
        // A load still in MEM cannot supply EX/MEM data; fall back to the WB check
        ForwardA = (~FWD_ON | reset | ~ex.valid) ? FWD_RF :
                   (exRsMem & ~mem.memread) ? FWD_EXMEM : exRsWb ? FWD_MEMWB : FWD_RF;
        ForwardB = (~FWD_ON | reset | ~ex.valid) ? FWD_RF :
                   (exRtMem & ~mem.memread) ? FWD_EXMEM : exRtWb ? FWD_MEMWB : FWD_RF;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ex <= '0;
            mem <= '0;
            wb <= '0;
            StallCount <= '0;
        end else begin
            wb <= mem;
            mem <= ex;
            ex <= (ID_Valid & ~Flush_ID_EX) ?
                  '{valid: 1'b1, regwrite: ID_RegWrite, memread: ID_MemRead, waddr: ID_WriteAddr,
                    rs: ID_Rs, rt: ID_Rt, usesRs: ID_UsesRs, usesRt: ID_UsesRt} : '0;
            if (Stall && StallCount != '1) StallCount <= StallCount + 1'b1;
        end
    end
endmodule
